// File: rtl/axis_lpf_channel_scheduler_pkg.sv
// Shared definitions for the multi-channel shift-based LPF scheduler:
// alpha field width, alpha type and the input-to-internal alignment helper.
package axis_lpf_channel_scheduler_pkg;

  localparam int unsigned ALPHA_W = 5;

  typedef logic [ALPHA_W-1:0] alpha_t;

  // Left shift that aligns a stream sample's binary point with the state's.
  function automatic int unsigned align_shift(input int unsigned internal_frac,
                                              input int unsigned io_frac);
    return internal_frac - io_frac;
  endfunction

endpackage

// File: rtl/lpf_rr_arbiter.sv
// Combinational round-robin arbiter: scans up from ptr (wrapping) and grants
// the first active request. The pointer itself is kept by the parent.
module lpf_rr_arbiter #(
  parameter int channel_bits = 2,
  localparam int NCH = 2 ** channel_bits
) (
  input  logic [NCH-1:0]          req,
  input  logic [channel_bits-1:0] ptr,
  output logic [NCH-1:0]          grant,
  output logic [channel_bits-1:0] grant_idx,
  output logic                    grant_valid
);

  logic [channel_bits-1:0] scan_idx;

  // First requester at or after ptr wins; index arithmetic wraps modulo NCH.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      scan_idx = ptr + channel_bits'(off);
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant[grant_idx] = grant_valid;
  end

endmodule

// File: rtl/axis_lpf_channel_scheduler.sv
// One first-order LPF kernel (y += (x - y) >>> alpha) shared round-robin
// across NCH AXI-Stream inputs; results leave on one tdest-tagged master.
module axis_lpf_channel_scheduler
  import axis_lpf_channel_scheduler_pkg::*;
#(
  parameter int channel_bits           = 2,
  parameter int inout_width            = 16,
  parameter int inout_decimal_width    = 15,
  parameter int internal_width         = 24,
  parameter int internal_decimal_width = 23,
  localparam int NCH = 2 ** channel_bits
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic [ALPHA_W*NCH-1:0]       i_alpha,
  input  logic                         i_clear,
  input  logic [NCH*inout_width-1:0]   s_axis_tdata,
  input  logic [NCH-1:0]               s_axis_tlast,
  input  logic [NCH-1:0]               s_axis_tvalid,
  output logic [NCH-1:0]               s_axis_tready,
  output logic [inout_width-1:0]       m_axis_tdata,
  output logic [channel_bits-1:0]      m_axis_tdest,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
);

  localparam int W  = internal_width;
  localparam int IW = inout_width;
  localparam int SH = int'(align_shift(internal_decimal_width, inout_decimal_width));

  logic [channel_bits-1:0] ptr_q;
  logic [W-1:0]            state_q [NCH];

  logic                    out_free;
  logic [NCH-1:0]          req;
  logic [NCH-1:0]          grant;
  logic [channel_bits-1:0] grant_idx;
  logic                    grant_valid;

  logic [IW-1:0]           sel_data;
  alpha_t                  sel_alpha;
  logic                    sel_last;
  logic [W-1:0]            sel_state;

  logic signed [W-1:0]     x_ext;
  logic signed [W-1:0]     x_int;
  logic signed [W:0]       diff;
  logic signed [W:0]       step;
  logic [W-1:0]            state_next;
  logic                    unused_step_msb;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign req      = s_axis_tvalid & {NCH{out_free && !i_clear}};

  lpf_rr_arbiter #(
    .channel_bits (channel_bits)
  ) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign s_axis_tready = grant & {NCH{resetn}};

  // Route the granted channel's sample, alpha, tlast and state to the kernel.
  always_comb begin
    sel_data  = '0;
    sel_alpha = '0;
    sel_last  = 1'b0;
    sel_state = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant_idx == channel_bits'(k)) begin
        sel_data  = s_axis_tdata[k*IW +: IW];
        sel_alpha = i_alpha[k*ALPHA_W +: ALPHA_W];
        sel_last  = s_axis_tlast[k];
        sel_state = state_q[k];
      end
    end
  end

  // Kernel: difference at W+1 bits, arithmetic shift, then add back. The new
  // state lies between old state and x, so the W-bit wrap-add is exact.
  always_comb begin
    x_ext      = W'(signed'(sel_data));
    x_int      = x_ext <<< SH;
    diff       = {x_int[W-1], x_int} - {sel_state[W-1], sel_state};
    step       = diff >>> sel_alpha;
    state_next = sel_state + step[W-1:0];
  end

  assign unused_step_msb = step[W];

  // State bank: global clear, otherwise single write port on the granted channel.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NCH; k++) state_q[k] <= '0;
    end else if (i_clear) begin
      for (int unsigned k = 0; k < NCH; k++) state_q[k] <= '0;
    end else if (grant_valid) begin
      state_q[grant_idx] <= state_next;
    end
  end

  // Round-robin pointer moves past the channel just served.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (grant_valid) begin
      ptr_q <= grant_idx + 1'b1;
    end
  end

  // Output register: load on transfer, drop valid when drained, hold on stall.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (grant_valid) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= state_next[SH +: IW];
      m_axis_tdest  <= grant_idx;
      m_axis_tlast  <= sel_last;
    end else if (out_free) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_lpf_channel_scheduler.sv
// Self-checking bench: randomized and directed traffic compared every cycle
// against an arithmetic model of the scheduler, plus literal expectations.
module tb_axis_lpf_channel_scheduler;

  localparam int CB  = 2;
  localparam int NCH = 4;
  localparam int IW  = 16;

  logic              aclk = 1'b0;
  logic              resetn;
  logic [5*NCH-1:0]  i_alpha;
  logic              i_clear;
  logic [NCH*IW-1:0] s_axis_tdata;
  logic [NCH-1:0]    s_axis_tlast;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tready;
  logic [IW-1:0]     m_axis_tdata;
  logic [CB-1:0]     m_axis_tdest;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  axis_lpf_channel_scheduler #(
    .channel_bits           (CB),
    .inout_width            (IW),
    .inout_decimal_width    (15),
    .internal_width         (24),
    .internal_decimal_width (23)
  ) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .i_alpha       (i_alpha),
    .i_clear       (i_clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: real-valued-ish integer state per channel (scaled 2^23).
  longint    st [NCH];
  int        ptr;
  bit        ev;
  logic [15:0] ed;
  int        edst;
  bit        el;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) st[k] = 0;
    ptr = 0; ev = 0; ed = '0; edst = 0; el = 0;
  endtask

  // Inputs are already driven (just after a negedge). Check grant, advance the
  // model across the next rising edge, then check outputs at the negedge.
  task automatic cyc();
    int          g;
    bit          free;
    logic [NCH-1:0] exp_rdy;
    longint      x, d;
    int          a;
    #1;
    free = !ev || m_axis_tready;
    g = -1;
    if (free && !i_clear)
      for (int off = 0; off < NCH; off++)
        if (g < 0 && s_axis_tvalid[(ptr + off) % NCH]) g = (ptr + off) % NCH;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    if (i_clear) for (int k = 0; k < NCH; k++) st[k] = 0;
    if (g >= 0) begin
      x = longint'($signed(s_axis_tdata[g*IW +: IW])) * 256;
      a = int'(i_alpha[g*5 +: 5]);
      d = x - st[g];
      st[g] = st[g] + (d >>> a);
      ev   = 1;
      ed   = 16'(st[g] >>> 8);
      edst = g;
      el   = s_axis_tlast[g];
      ptr  = (g + 1) % NCH;
    end else if (free) begin
      ev = 0;
    end
    @(negedge aclk);
    check("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
    if (ev) begin
      check("m_tdata", 32'(m_axis_tdata), 32'(ed));
      check("m_tdest", 32'(m_axis_tdest), 32'(edst));
      check("m_tlast", 32'(m_axis_tlast), 32'(el));
    end
  endtask

  task automatic randomize_inputs();
    s_axis_tvalid = NCH'($urandom);
    s_axis_tlast  = NCH'($urandom);
    for (int k = 0; k < NCH; k++) begin
      s_axis_tdata[k*IW +: IW] = IW'($urandom);
      i_alpha[k*5 +: 5]        = 5'($urandom_range(0, 31));
    end
    m_axis_tready = ($urandom_range(0, 3) != 0);
    i_clear       = ($urandom_range(0, 15) == 0);
  endtask

  initial begin : main
    int   n3;
    logic [15:0] held;

    resetn = 1'b0; i_clear = 1'b0; i_alpha = '0;
    s_axis_tdata = '0; s_axis_tlast = '0; s_axis_tvalid = '0; m_axis_tready = 1'b0;
    model_reset();
    repeat (3) @(negedge aclk);
    resetn = 1'b1;

    // Fairness: all channels valid, first grant ch0, then strict rotation.
    s_axis_tvalid = '1; m_axis_tready = 1'b1; i_alpha = {4{5'd3}};
    for (int k = 0; k < NCH; k++) s_axis_tdata[k*IW +: IW] = 16'(k * 1000);
    #1 check("first_grant", 32'(s_axis_tready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("rr_tdest", 32'(m_axis_tdest), 32'(k % 4));
    end

    // Clear during traffic: nothing granted that cycle.
    i_clear = 1'b1;
    #1 check("clear_no_grant", 32'(s_axis_tready), 32'h0);
    cyc();
    i_clear = 1'b0;

    // Step response on ch1, alpha=2.
    s_axis_tvalid = 4'b0010; i_alpha = {4{5'd2}};
    s_axis_tdata[1*IW +: IW] = 16'h4000;
    cyc(); check("step0", 32'(m_axis_tdata), 32'h1000); check("step0_dest", 32'(m_axis_tdest), 32'd1);
    cyc(); check("step1", 32'(m_axis_tdata), 32'h1C00);
    cyc(); check("step2", 32'(m_axis_tdata), 32'h2500);

    // Independence: ch0 alpha=0 full-scale positive, ch3 alpha=4 full-scale negative.
    i_clear = 1'b1; s_axis_tvalid = '0; cyc(); i_clear = 1'b0;
    i_alpha = '0; i_alpha[3*5 +: 5] = 5'd4;
    s_axis_tdata[0*IW +: IW] = 16'h7FFF;
    s_axis_tdata[3*IW +: IW] = 16'h8000;
    s_axis_tvalid = 4'b1001;
    n3 = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (m_axis_tdest == 2'd0) check("ind_ch0", 32'(m_axis_tdata), 32'h7FFF);
      else begin
        check("ind_ch3", 32'(m_axis_tdata), (n3 == 0) ? 32'hF800 : 32'hF080);
        n3++;
      end
    end

    // Backpressure: output pending, downstream stalls for 5 cycles.
    s_axis_tvalid = '1; m_axis_tready = 1'b1;
    cyc();
    m_axis_tready = 1'b0;
    held = ed;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_tready", 32'(s_axis_tready), 32'h0);
      cyc();
      check("bp_hold", 32'(m_axis_tdata), 32'(held));
    end
    m_axis_tready = 1'b1;
    repeat (4) cyc();

    // Clear then ch2 sample with tlast.
    s_axis_tvalid = 4'b0100; s_axis_tlast = 4'b0100;
    i_alpha[2*5 +: 5] = 5'd1;
    s_axis_tdata[2*IW +: IW] = 16'h2000;
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    cyc();
    check("clr_ch2_data", 32'(m_axis_tdata), 32'h1000);
    check("clr_ch2_dest", 32'(m_axis_tdest), 32'd2);
    check("clr_ch2_last", 32'(m_axis_tlast), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cyc();
    end

    // Asynchronous reset mid-stream.
    randomize_inputs();
    s_axis_tvalid = '1;
    #3 resetn = 1'b0;
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_tdata",  32'(m_axis_tdata),  32'h0);
    check("rst_tdest",  32'(m_axis_tdest),  32'h0);
    check("rst_tlast",  32'(m_axis_tlast),  32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'h0);
    model_reset();
    repeat (2) @(negedge aclk);
    resetn = 1'b1; i_clear = 1'b0; m_axis_tready = 1'b1;
    #1 check("rst_first_grant", 32'(s_axis_tready), 32'h1);
    for (int n = 0; n < 200; n++) begin
      cyc();
      randomize_inputs();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
